td4_sequencer: RTL and testbench

- Control unit for the TD4 4-bit CPU.
- Owns the program counter, carry flag and run/halt state.
- Each cycle it decodes the 8-bit instruction fetched at the current PC, drives the 2-bit source select of the 4-way data selector, and asserts the load enables for registers A, B, OUT and PC.
- Sits between the program ROM, the data selector, the 4-bit adder and the register file.

---
 rtl/td4_pkg.sv | 27 ++
 rtl/td4_decode.sv | 39 +++
 rtl/td4_sequencer.sv | 103 ++++++++++
 tb/tb_td4_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/td4_pkg.sv
// Shared opcodes, data-selector codes and run/halt state encoding for the TD4 control unit.
package td4_pkg;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_A  = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_B  = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_IM = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  localparam logic [1:0] SEL_A    = 2'd0;
  localparam logic [1:0] SEL_B    = 2'd1;
  localparam logic [1:0] SEL_IN   = 2'd2;
  localparam logic [1:0] SEL_ZERO = 2'd3;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

endpackage

// File: rtl/td4_decode.sv
// Combinational TD4 opcode decoder: selector code, one-hot load enables and undefined flag.
module td4_decode
  import td4_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       carry_flag,
  output logic [1:0] sel,
  output logic       ld_a,
  output logic       ld_b,
  output logic       ld_out,
  output logic       ld_pc,
  output logic       undef
);

  always_comb begin
    sel    = SEL_ZERO;
    ld_a   = 1'b0;
    ld_b   = 1'b0;
    ld_out = 1'b0;
    ld_pc  = 1'b0;
    undef  = 1'b0;
    unique case (opcode)
      OP_ADD_A:  begin sel = SEL_A;    ld_a   = 1'b1; end
      OP_ADD_B:  begin sel = SEL_B;    ld_b   = 1'b1; end
      OP_MOV_A:  begin sel = SEL_ZERO; ld_a   = 1'b1; end
      OP_MOV_B:  begin sel = SEL_ZERO; ld_b   = 1'b1; end
      OP_MOV_AB: begin sel = SEL_B;    ld_a   = 1'b1; end
      OP_MOV_BA: begin sel = SEL_A;    ld_b   = 1'b1; end
      OP_IN_A:   begin sel = SEL_IN;   ld_a   = 1'b1; end
      OP_IN_B:   begin sel = SEL_IN;   ld_b   = 1'b1; end
      OP_OUT_B:  begin sel = SEL_B;    ld_out = 1'b1; end
      OP_OUT_IM: begin sel = SEL_ZERO; ld_out = 1'b1; end
      OP_JMP:    begin sel = SEL_ZERO; ld_pc  = 1'b1; end
      OP_JNC:    begin sel = SEL_ZERO; ld_pc  = ~carry_flag; end
      default:   undef = 1'b1;
    endcase
  end

endmodule

// File: rtl/td4_sequencer.sv
// TD4 control unit: PC, carry flag, run/halt FSM and load gating around td4_decode.
// Define TD4_UNDEF_TRAP_EN to halt with a sticky trap on undefined opcodes instead of a NOP.
module td4_sequencer
  import td4_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned IMM_W  = 4
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [IMM_W+3:0]  instr,
  input  logic              alu_carry,
  input  logic              halt_req,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        sel,
  output logic              ld_a,
  output logic              ld_b,
  output logic              ld_out,
  output logic              ld_pc,
  output logic [IMM_W-1:0]  imm,
  output logic              carry_flag,
  output logic              halted,
  output logic              trap
);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              carry_q;
  logic              trap_q;

  logic [1:0] dec_sel;
  logic       dec_ld_a, dec_ld_b, dec_ld_out, dec_ld_pc, undef;
  logic       run, trap_hit;

  assign imm = instr[IMM_W-1:0];

  td4_decode u_decode (
    .opcode     (instr[IMM_W+:4]),
    .carry_flag (carry_q),
    .sel        (dec_sel),
    .ld_a       (dec_ld_a),
    .ld_b       (dec_ld_b),
    .ld_out     (dec_ld_out),
    .ld_pc      (dec_ld_pc),
    .undef      (undef)
  );

`ifdef TD4_UNDEF_TRAP_EN
  assign trap_hit = undef;
`else
  logic unused_undef;
  assign unused_undef = undef;
  assign trap_hit     = 1'b0;
`endif

  // Reset must hold every enable low even though decode follows instr combinationally.
  assign run    = n_reset && (state_q == ST_RUN);
  assign ld_a   = run & dec_ld_a;
  assign ld_b   = run & dec_ld_b;
  assign ld_out = run & dec_ld_out;
  assign ld_pc  = run & dec_ld_pc;

  always_comb begin
    sel = 2'd0;
    if (n_reset) sel = (state_q == ST_HALT) ? SEL_ZERO : dec_sel;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      carry_q <= 1'b0;
      trap_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (trap_hit) begin
            state_q <= ST_HALT;
            trap_q  <= 1'b1;
          end else begin
            pc_q    <= dec_ld_pc ? ADDR_W'(imm) : pc_q + ADDR_W'(1);
            carry_q <= alu_carry;
            if (halt_req) state_q <= ST_HALT;
          end
        end
        ST_HALT: begin
          if (resume && !halt_req) begin
            state_q <= ST_RUN;
            trap_q  <= 1'b0;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign pc         = pc_q;
  assign carry_flag = carry_q;
  assign halted     = (state_q == ST_HALT);
  assign trap       = trap_q;

endmodule

// File: tb/tb_td4_sequencer.sv
// Self-checking bench for td4_sequencer: decode table, directed corner sequences and a
// randomized run against an instruction-level model of the TD4 control unit.
module tb_td4_sequencer;

`ifdef TD4_UNDEF_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       n_reset;
  logic [7:0] instr;
  logic       alu_carry, halt_req, resume;
  logic [3:0] pc, imm;
  logic [1:0] sel;
  logic       ld_a, ld_b, ld_out, ld_pc, carry_flag, halted, trap;
  logic [5:0] outs;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  td4_sequencer dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .instr      (instr),
    .alu_carry  (alu_carry),
    .halt_req   (halt_req),
    .resume     (resume),
    .pc         (pc),
    .sel        (sel),
    .ld_a       (ld_a),
    .ld_b       (ld_b),
    .ld_out     (ld_out),
    .ld_pc      (ld_pc),
    .imm        (imm),
    .carry_flag (carry_flag),
    .halted     (halted),
    .trap       (trap)
  );

  assign outs = {sel, ld_a, ld_b, ld_out, ld_pc};

  // Spec decode table; ld is {a, b, out, pc}.
  typedef struct packed {
    logic       def;
    logic [1:0] s;
    logic [3:0] ld;
  } exp_t;

  function automatic exp_t spec_dec(input logic [3:0] op, input logic cf);
    exp_t e;
    e = '{def: 1'b1, s: 2'd3, ld: 4'b0000};
    case (op)
      4'b0000: begin e.s = 2'd0; e.ld = 4'b1000; end
      4'b0101: begin e.s = 2'd1; e.ld = 4'b0100; end
      4'b0011: begin e.s = 2'd3; e.ld = 4'b1000; end
      4'b0111: begin e.s = 2'd3; e.ld = 4'b0100; end
      4'b0001: begin e.s = 2'd1; e.ld = 4'b1000; end
      4'b0100: begin e.s = 2'd0; e.ld = 4'b0100; end
      4'b0010: begin e.s = 2'd2; e.ld = 4'b1000; end
      4'b0110: begin e.s = 2'd2; e.ld = 4'b0100; end
      4'b1001: begin e.s = 2'd1; e.ld = 4'b0010; end
      4'b1011: begin e.s = 2'd3; e.ld = 4'b0010; end
      4'b1111: begin e.s = 2'd3; e.ld = 4'b0001; end
      4'b1110: begin e.s = 2'd3; e.ld = cf ? 4'b0000 : 4'b0001; end
      default: e.def = 1'b0;
    endcase
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    instr = 8'h00; alu_carry = 1'b0; halt_req = 1'b0; resume = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    #1;
  endtask

  // Step through n MOV A,0 instructions with the given adder carry.
  task automatic advance(input int n, input logic ac);
    instr = 8'b0011_0000;
    alu_carry = ac;
    repeat (n) tick();
  endtask

  typedef struct packed {
    logic [3:0] op;
    logic       cf;
    logic [1:0] s;
    logic [3:0] ld;
    logic       def;
  } vec_t;

  vec_t vecs [15];
  logic [3:0] m_pc;
  logic       m_cf, m_h, m_t;

  initial begin
    vecs[0]  = '{4'b0000, 1'b0, 2'd0, 4'b1000, 1'b1};
    vecs[1]  = '{4'b0101, 1'b0, 2'd1, 4'b0100, 1'b1};
    vecs[2]  = '{4'b0011, 1'b1, 2'd3, 4'b1000, 1'b1};
    vecs[3]  = '{4'b0111, 1'b0, 2'd3, 4'b0100, 1'b1};
    vecs[4]  = '{4'b0001, 1'b0, 2'd1, 4'b1000, 1'b1};
    vecs[5]  = '{4'b0100, 1'b1, 2'd0, 4'b0100, 1'b1};
    vecs[6]  = '{4'b0010, 1'b0, 2'd2, 4'b1000, 1'b1};
    vecs[7]  = '{4'b0110, 1'b0, 2'd2, 4'b0100, 1'b1};
    vecs[8]  = '{4'b1001, 1'b0, 2'd1, 4'b0010, 1'b1};
    vecs[9]  = '{4'b1011, 1'b1, 2'd3, 4'b0010, 1'b1};
    vecs[10] = '{4'b1111, 1'b1, 2'd3, 4'b0001, 1'b1};
    vecs[11] = '{4'b1110, 1'b0, 2'd3, 4'b0001, 1'b1};
    vecs[12] = '{4'b1110, 1'b1, 2'd3, 4'b0000, 1'b1};
    vecs[13] = '{4'b1000, 1'b0, 2'd0, 4'b0000, 1'b0};
    vecs[14] = '{4'b1101, 1'b1, 2'd0, 4'b0000, 1'b0};

    // Reset state, with an instruction that would otherwise load A.
    n_reset = 1'b0; instr = 8'b0011_0101; alu_carry = 1'b1; halt_req = 1'b0; resume = 1'b0;
    #3;
    check("reset_outs", outs, 6'd0);
    check("reset_pc", pc, 4'd0);
    check("reset_carry", carry_flag, 1'b0);
    check("reset_halted", halted, 1'b0);
    check("reset_trap", trap, 1'b0);

    // Decode table: prime carry_flag with an ADD, then present the opcode.
    for (int i = 0; i < 15; i++) begin
      do_reset();
      instr = 8'b0000_0000;
      alu_carry = vecs[i].cf;
      tick();
      instr = {vecs[i].op, 4'h5};
      alu_carry = 1'b0;
      #1;
      if (vecs[i].def) check($sformatf("dec_%b_cf%0d", vecs[i].op, vecs[i].cf), outs,
                             {vecs[i].s, vecs[i].ld});
      else check($sformatf("undef_lds_%b", vecs[i].op), outs[3:0], vecs[i].ld);
    end

    // MOV A,5 then ADD A,3 from reset.
    do_reset();
    instr = 8'b0011_0101; #1;
    check("prog_c0_outs", outs, 6'b11_1000);
    check("prog_c0_imm", imm, 4'd5);
    tick();
    check("prog_pc1", pc, 4'd1);
    instr = 8'b0000_0011; #1;
    check("prog_c1_outs", outs, 6'b00_1000);
    tick();
    check("prog_pc2", pc, 4'd2);

    // JMP at 4 -> 10, JMP 15, sequential wrap to 0.
    advance(2, 1'b0);
    check("jmp_pre_pc", pc, 4'd4);
    instr = 8'b1111_1010; tick();
    check("jmp_pc", pc, 4'd10);
    instr = 8'b1111_1111; tick();
    check("jmp15_pc", pc, 4'd15);
    advance(1, 1'b0);
    check("wrap_pc", pc, 4'd0);

    // JNC not taken after a carry, taken after no carry (flag is the registered one).
    do_reset();
    instr = 8'b0000_0001; alu_carry = 1'b1; tick();
    check("jnc_cf_set", carry_flag, 1'b1);
    instr = 8'b1110_1001; alu_carry = 1'b0; #1;
    check("jnc_nt_ldpc", ld_pc, 1'b0);
    tick();
    check("jnc_nt_pc", pc, 4'd2);
    instr = 8'b0000_0001; alu_carry = 1'b0; tick();
    instr = 8'b1110_1001; alu_carry = 1'b1; #1;
    check("jnc_t_ldpc", ld_pc, 1'b1);
    tick();
    check("jnc_t_pc", pc, 4'd9);

    // Halt at pc=3: instruction completes, then hold with loads off.
    do_reset();
    advance(3, 1'b0);
    instr = 8'b0011_0111; halt_req = 1'b1; alu_carry = 1'b1; #1;
    check("halt_req_outs", outs, 6'b11_1000);
    tick();
    check("halt_pc", pc, 4'd4);
    check("halt_halted", halted, 1'b1);
    check("halt_carry", carry_flag, 1'b1);
    halt_req = 1'b0; alu_carry = 1'b0; instr = 8'b1111_0001;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("halt_hold_outs", outs, 6'b11_0000);
      tick();
      check("halt_hold_pc", pc, 4'd4);
    end
    check("halt_hold_carry", carry_flag, 1'b1);
    halt_req = 1'b1; resume = 1'b1; tick();
    check("resume_ignored", halted, 1'b1);
    halt_req = 1'b0; tick();
    resume = 1'b0;
    check("resume_halted", halted, 1'b0);
    check("resume_pc", pc, 4'd4);
    instr = 8'b0011_0000; tick();
    check("resume_pc_next", pc, 4'd5);

    // Halt alongside a JMP: jump lands, then HALT; reset mid-HALT returns to RUN.
    instr = 8'b1111_1100; halt_req = 1'b1; tick();
    halt_req = 1'b0;
    check("jmp_halt_pc", pc, 4'd12);
    check("jmp_halt_halted", halted, 1'b1);
    #2 n_reset = 1'b0; #1;
    check("rst_in_halt", {halted, pc}, 5'd0);
    @(negedge clk); n_reset = 1'b1;

    // Asynchronous reset mid-cycle at pc=9.
    do_reset();
    advance(9, 1'b1);
    check("arst_pre_pc", pc, 4'd9);
    instr = 8'b0000_0000; #2;
    n_reset = 1'b0; #1;
    check("arst_pc", pc, 4'd0);
    check("arst_carry", carry_flag, 1'b0);
    check("arst_outs", outs, 6'd0);
    @(negedge clk); n_reset = 1'b1;

    // Undefined opcode 1000 at pc=6.
    do_reset();
    advance(6, 1'b0);
    instr = 8'b1000_0011; alu_carry = 1'b1; #1;
    check("undef6_lds", outs[3:0], 4'd0);
    tick();
    check("undef6_pc", pc, TrapEn ? 4'd6 : 4'd7);
    check("undef6_halted", halted, TrapEn);
    check("undef6_trap", trap, TrapEn);
    check("undef6_carry", carry_flag, !TrapEn);
    instr = 8'b0011_0000; alu_carry = 1'b0; tick();
    check("undef6_trap_sticky", trap, TrapEn);
    resume = 1'b1; tick(); resume = 1'b0;
    check("undef6_trap_clear", trap, 1'b0);

    // Randomized run against the instruction-level model.
    do_reset();
    m_pc = 4'd0; m_cf = 1'b0; m_h = 1'b0; m_t = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic [7:0] ins;
      logic       ac, hr, rs;
      exp_t       e;
      ins = 8'($urandom);
      ac  = 1'($urandom);
      hr  = ($urandom_range(0, 7) == 0);
      rs  = ($urandom_range(0, 2) == 0);
      instr = ins; alu_carry = ac; halt_req = hr; resume = rs;
      #1;
      e = spec_dec(ins[7:4], m_cf);
      if (m_h) check("rnd_halt_outs", outs, 6'b11_0000);
      else if (e.def) check("rnd_outs", outs, {e.s, e.ld});
      else check("rnd_undef_lds", outs[3:0], 4'd0);
      tick();
      if (m_h) begin
        if (rs && !hr) begin m_h = 1'b0; m_t = 1'b0; end
      end else if (!e.def && TrapEn) begin
        m_h = 1'b1; m_t = 1'b1;
      end else begin
        m_pc = e.ld[0] ? ins[3:0] : m_pc + 4'd1;
        m_cf = ac;
        if (hr) m_h = 1'b1;
      end
      check("rnd_pc", pc, m_pc);
      check("rnd_carry", carry_flag, m_cf);
      check("rnd_halted", halted, m_h);
      check("rnd_trap", trap, m_t);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
